// File: rtl/overture_sequencer_pkg.sv
// Shared types and constants for the overture fetch/decode/branch sequencer.
package overture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_IMM  = 2'b00,
    MODE_ALU  = 2'b01,
    MODE_COPY = 2'b10,
    MODE_COND = 2'b11
  } mode_t;

  localparam int MODE_MSB = 7;
  localparam int MODE_LSB = 6;

  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_LT     = 3'b010;
  localparam logic [2:0] COND_LE     = 3'b011;
  localparam logic [2:0] COND_ALWAYS = 3'b100;
  localparam logic [2:0] COND_NE     = 3'b101;
  localparam logic [2:0] COND_GE     = 3'b110;
  localparam logic [2:0] COND_GT     = 3'b111;

  function automatic mode_t inst_mode(input logic [7:0] inst);
    return mode_t'(inst[MODE_MSB:MODE_LSB]);
  endfunction

endpackage

// File: rtl/overture_sequencer_if.sv
// Instruction-memory req/ack fetch channel between the sequencer and its memory.
interface overture_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [7:0]          imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/overture_sequencer_cond_eval.sv
// Branch condition evaluator: signed compare of a register against zero.
module cond_eval
  import overture_pkg::*;
(
  input  logic [2:0]        cond,
  input  logic signed [7:0] value,
  output logic              taken
);

  logic zero;
  logic neg;

  assign zero = (value == 8'sd0);
  assign neg  = (value < 8'sd0);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NEVER:  taken = 1'b0;
      COND_EQ:     taken = zero;
      COND_LT:     taken = neg;
      COND_LE:     taken = neg | zero;
      COND_ALWAYS: taken = 1'b1;
      COND_NE:     taken = ~zero;
      COND_GE:     taken = ~neg;
      COND_GT:     taken = ~neg & ~zero;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/overture_sequencer.sv
// Fetch/decode/branch control stage: fetches one instruction per req/ack
// transaction, then issues a single-cycle execute strobe and updates the pc.
module overture_sequencer
  import overture_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  overture_sequencer_if.master imem,
  input  logic [7:0]           reg0,
  input  logic [7:0]           reg3,
  output logic [7:0]           inst,
  output logic                 copy_en,
  output logic                 imm_en,
  output logic [7:0]           imm_val,
  output logic                 alu_en,
  output logic [2:0]           alu_op,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 halted
);

  state_t state_q;
  state_t state_d;
  mode_t  mode;
  logic   req;
  logic   cond_taken;
  logic   jump;

  assign mode    = inst_mode(inst);
  assign imm_val = {2'b00, inst[5:0]};
  assign alu_op  = inst[2:0];
  assign halted  = (state_q == ST_IDLE);

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  cond_eval u_cond_eval (
    .cond  (inst[2:0]),
    .value ($signed(reg3)),
    .taken (cond_taken)
  );

  assign jump = (mode == MODE_COND) && cond_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset beats a coincident ack, so a fetch cut short by rst never lands in inst.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst <= 8'h00;
    end else if (state_q == ST_FETCH && imem.imem_ack) begin
      inst <= imem.imem_data;
    end
  end

  // reg0/reg3 are sampled on the EXEC edge, before the register file writes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (state_q == ST_EXEC) begin
      pc <= jump ? reg0[PC_WIDTH-1:0] : pc + PC_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    imm_en  = 1'b0;
    alu_en  = 1'b0;
    copy_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        req = 1'b1;
        if (imem.imem_ack) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (mode)
          MODE_IMM:  imm_en  = 1'b1;
          MODE_ALU:  alu_en  = 1'b1;
          MODE_COPY: copy_en = 1'b1;
          default:   ;
        endcase
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_overture_sequencer.sv
// Scoreboard bench for overture_sequencer: the memory driver queues expected
// EXEC cycles, a monitor checks each EXEC and the pc that follows it.
module tb_overture_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] reg0;
  logic [7:0] reg3;
  logic [7:0] inst;
  logic       copy_en;
  logic       imm_en;
  logic [7:0] imm_val;
  logic       alu_en;
  logic [2:0] alu_op;
  logic [7:0] pc;
  logic       halted;

  overture_sequencer_if #(.PC_WIDTH(8)) bus ();

  overture_sequencer #(.PC_WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .imem    (bus),
    .reg0    (reg0),
    .reg3    (reg3),
    .inst    (inst),
    .copy_en (copy_en),
    .imm_en  (imm_en),
    .imm_val (imm_val),
    .alu_en  (alu_en),
    .alu_op  (alu_op),
    .pc      (pc),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] inst;
    logic       imm_en;
    logic       alu_en;
    logic       copy_en;
    logic [7:0] imm_val;
    logic [2:0] alu_op;
    logic [7:0] pc;
    logic [7:0] next_pc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_skip = 1'b0;
  logic [7:0] model_pc = 8'h00;
  logic [7:0] last_inst = 8'h00;

  // Hand-derived taken table, bit index = condition code, per reg3 class.
  localparam logic [7:0] TAKEN_NEG  = 8'b0011_1100;  // reg3 = 8'h80
  localparam logic [7:0] TAKEN_ZERO = 8'b0101_1010;  // reg3 = 8'h00
  localparam logic [7:0] TAKEN_POS  = 8'b1111_0000;  // reg3 = 8'h01

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_taken(input logic [2:0] c, input logic [7:0] r3);
    logic [7:0] m;
    m = (r3 == 8'h80) ? TAKEN_NEG : (r3 == 8'h00) ? TAKEN_ZERO : TAKEN_POS;
    return m[c];
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual no request required request within 20 cycles");
    end
  endtask

  task automatic serve(input logic [7:0] data, input int waits, input logic [7:0] r0,
                       input logic [7:0] r3, input bit drop_run);
    exp_t e;
    bit   ok;
    wait_req(ok);
    if (!ok) return;
    reg0 = r0;
    reg3 = r3;
    if (drop_run) run = 1'b0;
    chk("fetch_addr", bus.imem_addr, model_pc);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("wait_req", bus.imem_req, 1'b1);
      chk("wait_addr", bus.imem_addr, model_pc);
      chk("wait_inst", inst, last_inst);
      chk("wait_strobes", {imm_en, alu_en, copy_en}, 3'b000);
    end
    e.inst    = data;
    e.imm_en  = (data[7:6] == 2'b00);
    e.alu_en  = (data[7:6] == 2'b01);
    e.copy_en = (data[7:6] == 2'b10);
    e.imm_val = {2'b00, data[5:0]};
    e.alu_op  = data[2:0];
    e.pc      = model_pc;
    e.next_pc = (data[7:6] == 2'b11 && exp_taken(data[2:0], r3)) ? r0 : model_pc + 8'd1;
    sb.push_back(e);
    model_pc  = e.next_pc;
    last_inst = data;
    bus.imem_ack  = 1'b1;
    bus.imem_data = data;
    @(posedge clk);
    #1;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 8'hEE;
  endtask

  // EXEC is the only state with neither halted nor imem_req.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_skip && rst === 1'b0 && halted === 1'b0 && bus.imem_req === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_exec actual exec at pc %0h required no exec", pc);
        end else begin
          e = sb.pop_front();
          chk("inst", inst, e.inst);
          chk("imm_en", imm_en, e.imm_en);
          chk("alu_en", alu_en, e.alu_en);
          chk("copy_en", copy_en, e.copy_en);
          chk("imm_val", imm_val, e.imm_val);
          chk("alu_op", alu_op, e.alu_op);
          chk("exec_pc", pc, e.pc);
          @(negedge clk);
          chk("next_pc", pc, e.next_pc);
          chk("strobe_drop", {imm_en, alu_en, copy_en}, 3'b000);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    logic [7:0] rvals [3];
    rvals[0] = 8'h80;
    rvals[1] = 8'h00;
    rvals[2] = 8'h01;
    rst = 1'b1;
    run = 1'b0;
    reg0 = 8'h00;
    reg3 = 8'h00;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_halted", halted, 1'b1);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_inst", inst, 8'h00);
    chk("rst_strobes", {imm_en, alu_en, copy_en}, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b1;

    serve(8'h05, 0, 8'h00, 8'h00, 1'b0);
    serve(8'h8B, 3, 8'h00, 8'h00, 1'b0);
    serve(8'h44, 0, 8'h00, 8'h00, 1'b0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++)
        serve({5'b11000, 3'(c)}, 0, 8'h20, rvals[r], 1'b0);

    serve(8'hC4, 0, 8'hFF, 8'h00, 1'b0);
    serve(8'h3F, 0, 8'h20, 8'h00, 1'b0);
    serve(8'h41, 1, 8'h00, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    chk("idle_halted", halted, 1'b1);
    chk("idle_req", bus.imem_req, 1'b0);
    chk("idle_pc", pc, 8'h01);

    // Reset during FETCH with a coincident ack.
    @(posedge clk);
    #1;
    run = 1'b1;
    wait_req(ok);
    run = 1'b0;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 8'h7F;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    chk("rstf_req", bus.imem_req, 1'b0);
    chk("rstf_halted", halted, 1'b1);
    chk("rstf_inst", inst, 8'h00);
    chk("rstf_pc", pc, 8'h00);
    chk("rstf_strobes", {imm_en, alu_en, copy_en}, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_pc  = 8'h00;
    last_inst = 8'h00;

    // Reset during EXEC of an ALU instruction.
    mon_skip = 1'b1;
    run = 1'b1;
    wait_req(ok);
    bus.imem_ack  = 1'b1;
    bus.imem_data = 8'h44;
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    chk("rste_alu_en", alu_en, 1'b1);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    chk("rste_alu_drop", alu_en, 1'b0);
    chk("rste_pc", pc, 8'h00);
    chk("rste_inst", inst, 8'h00);
    chk("rste_halted", halted, 1'b1);
    chk("rste_req", bus.imem_req, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_skip = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/overture_sequencer.md
# overture_sequencer

Fetch/decode/branch control stage sitting directly upstream of the six-register copy file. Fetches one 8-bit instruction per transaction from an external instruction memory over a req/ack handshake, holds it on `inst`, and emits one-cycle execute strobes: register-file copy enable, immediate load, ALU enable. Resolves conditional jumps from the register file's `reg0` (target) and `reg3` (condition operand).

## Interface
- `PC_WIDTH`, 8, program counter and instruction-address width; PC wraps modulo 2^PC_WIDTH.
- `clk`  in  1  single clock, all state on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; permits starting or continuing instruction fetch.
- `imem_req`  out  1  fetch request, held until acknowledged.
- `imem_addr`  out  PC_WIDTH  fetch address (= pc while `imem_req`).
- `imem_ack`  in  1  memory has `imem_data` valid this cycle.
- `imem_data`  in  8  fetched instruction.
- `reg0`  in  8  jump target, from register file.
- `reg3`  in  8  condition operand (two's complement), from register file.
- `inst`  out  8  latched current instruction, drives register file `inst`.
- `copy_en`  out  1  register-file `enable` strobe.
- `imm_en`  out  1  immediate-load strobe (datapath writes reg0).
- `imm_val`  out  8  `{2'b00, inst[5:0]}`.
- `alu_en`  out  1  ALU strobe (datapath writes reg3).
- `alu_op`  out  3  `inst[2:0]`.
- `pc`  out  PC_WIDTH  program counter.
- `halted`  out  1  high in IDLE.

## Operation
- Mode = `inst[7:6]`: 00 IMM, 01 ALU, 10 COPY, 11 COND.
- States: IDLE, FETCH, EXEC.
- IDLE: no strobes, `imem_req`=0. `run`=1 -> FETCH.
- FETCH: `imem_req`=1, `imem_addr`=pc, both stable until ack. On a cycle with `imem_ack`=1: latch `imem_data` into `inst`, go to EXEC. `run` ignored in FETCH; a started fetch always completes.
- EXEC (exactly one cycle): exactly one strobe per mode:
  - IMM -> `imm_en`.
  - ALU -> `alu_en`.
  - COPY -> `copy_en`.
  - COND -> no strobe.
- PC update at end of EXEC: COND with condition true -> pc <= reg0[PC_WIDTH-1:0]; otherwise pc <= pc+1, wrapping from all-ones to 0.
- Condition on signed `reg3`, code `inst[2:0]`:
  - 000 never; 001 ==0; 010 <0; 011 <=0.
  - 100 always; 101 !=0; 110 >=0; 111 >0.
- After EXEC: `run`=1 -> FETCH, else IDLE.
- `imm_val` and `alu_op` are decoded from `inst` continuously; consumers qualify them with their strobes.

## Timing
- Reset values: state IDLE, pc 0, `inst` 0, all strobes 0, `imem_req` 0, `halted` 1.
- Throughput: zero-wait memory (ack in first FETCH cycle) gives 2 cycles/instruction. Each wait cycle adds 1.
- `reg0`/`reg3` are sampled in the EXEC cycle, before that edge's register write. A COND after an ALU sees the updated reg3, since the ALU wrote at the previous EXEC edge.
- Strobes are registered-state decodes: high only in EXEC, never in FETCH/IDLE.
- `rst` mid-FETCH: `imem_req` low the next cycle; an ack coincident with `rst` is ignored and `inst` becomes 0.
- `rst` in EXEC: strobes drop next cycle and pc becomes 0. The register file also resets on the same edge.
- `imem_ack` outside FETCH is ignored.

## Structure
- Package `overture_pkg`:
  - state enum;
  - mode enum (IMM/ALU/COPY/COND);
  - 3-bit condition code constants;
  - `MODE_*` field positions.
- Sub-module `cond_eval`: combinational, (`cond[2:0]`, `value[7:0]`) -> `taken`. Shared with any later branch-prediction work.
- Top holds the FSM, pc register, instruction latch and strobe decode.

## Test plan
- Reset then `run`=1, memory returns 8'h05 with zero wait -> `imem_req` at pc 0, EXEC next cycle with `imm_en`=1 and `imm_val`=8'h05, pc=1, next FETCH at address 1.
- Ack delayed 3 cycles -> `imem_req`/`imem_addr` stable for 4 cycles, `inst` unchanged until ack edge, EXEC occurs exactly once.
- COPY 8'b10_001_011 -> `copy_en` high one cycle, `inst`=8'h8B; ALU 8'h44 -> `alu_en`=1, `alu_op`=3'b100.
- COND sweep, all 8 codes with reg3 in {8'h80, 8'h00, 8'h01} and reg0=8'h20 -> pc=8'h20 when taken per the table, else pc+1.
- pc=8'hFF non-jump -> pc wraps to 8'h00; `run` dropped during FETCH -> fetch completes, EXEC, then IDLE with `halted`=1.
- `rst` asserted mid-FETCH and mid-EXEC -> all outputs at reset values next cycle, and a coincident ack is ignored.
